// File: rtl/sub_borrow_pipe.sv
// Two-stage pipelined WIDTH-bit subtractor (diff = a - b - borrow_in) with borrow
// chaining across the beats of a multi-word transfer, plus running zero and signed-overflow flags.
module sub_borrow_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             first,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_last,
    output logic             zero,
    output logic             ovf
);

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             first;
        logic             last;
        logic             ovf_raw;
    } s1_t;

    logic             r_s1_valid;
    s1_t              r_s1;
    logic             r_chain_borrow;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_out_last;
    logic             r_zero;
    logic             r_ovf;
    logic             r_zacc;

    logic             w_accept;
    logic             w_s2_load;
    logic             w_borrow_in;
    logic [WIDTH:0]   w_sub;
    s1_t              w_s1_next;
    logic             w_zero;

    // Stage 1 may refill in the same cycle it hands its beat to stage 2.
    assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);

    // NOTE: every signal written here gets a value on all paths, defaults first, so no latch is inferred.
    always_comb begin
        w_s1_next         = '0;
        w_borrow_in       = first ? bin : r_chain_borrow;
        w_sub             = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_borrow_in};
        w_s1_next.diff    = w_sub[WIDTH-1:0];
        w_s1_next.bout    = w_sub[WIDTH];
        w_s1_next.first   = first;
        w_s1_next.last    = last;
        w_s1_next.ovf_raw = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
        w_zero            = (r_s1.first ? 1'b1 : r_zacc) && (r_s1.diff == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1           <= '0;
            r_chain_borrow <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid     <= 1'b1;
            r_s1           <= w_s1_next;
            r_chain_borrow <= w_s1_next.bout;
        end else if (w_s2_load) begin
            r_s1_valid     <= 1'b0;
        end
    end

    // The zero accumulator re-arms after the last word so the next transfer starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_last  <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zacc      <= 1'b1;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_diff      <= r_s1.diff;
            r_bout      <= r_s1.bout;
            r_out_last  <= r_s1.last;
            r_zero      <= w_zero;
            r_ovf       <= r_s1.last && r_s1.ovf_raw;
            r_zacc      <= r_s1.last ? 1'b1 : w_zero;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign out_last  = r_out_last;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sub_borrow_pipe.sv
// Directed bench for sub_borrow_pipe: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge, expected values are hand-computed.
module tb_sub_borrow_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             first = 1'b0;
    logic             last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             out_last;
    logic             zero;
    logic             ovf;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic       first;
        logic       last;
        logic [7:0] d;
        logic       bo;
        logic       ol;
        logic       z;
        logic       ov;
    } vec_t;

    sub_borrow_pipe #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .first    (first),
        .last     (last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout),
        .out_last (out_last),
        .zero     (zero),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Entered 1ns after a rising edge; returns 1ns after the edge that accepted the beat.
    task automatic send(input vec_t v, output int cycles);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        bin      = v.bin;
        first    = v.first;
        last     = v.last;
        cycles   = 0;
        while (cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", cycles);
    endtask

    // Returns {diff,bout,out_last,zero,ovf} of the next consumed beat, 1ns after the consuming edge.
    task automatic get_out(output logic [11:0] res, output int lat);
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (out_valid && out_ready) begin
                res = {diff, bout, out_last, zero, ovf};
                @(posedge clk);
                #1;
                return;
            end
        end
        res = 'x;
        total++;
        bad++;
        $display("FAIL output_timeout: out_valid stayed 0 for %0d cycles, required 1", lat);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, diff, bout, out_last, zero, ovf} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {out_valid, diff, bout, out_last, zero, ovf});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        vec_t v = '{8'h05, 8'h03, 1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [11:0] res;
        int c;
        int lat;
        send(v, c);
        in_valid = 1'b0;
        get_out(res, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles, required 2", lat);
        end
        total++;
        if (res !== {v.d, v.bo, v.ol, v.z, v.ov}) begin
            bad++;
            $display("FAIL single_payload: got %h/%b/%b/%b/%b, required %h/%b/%b/%b/%b",
                     res[11:4], res[3], res[2], res[1], res[0], v.d, v.bo, v.ol, v.z, v.ov);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain: out_valid got %b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_borrow_ovf();
        vec_t v [3];
        logic [11:0] res;
        int c;
        int lat;
        v[0] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        v[1] = '{8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1};
        v[2] = '{8'h10, 8'h0F, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send(v[i], c);
            in_valid = 1'b0;
            get_out(res, lat);
            total++;
            if (res !== {v[i].d, v[i].bo, v[i].ol, v[i].z, v[i].ov}) begin
                bad++;
                $display("FAIL borrow_ovf[%0d]: got %h/%b/%b/%b/%b, required %h/%b/%b/%b/%b", i,
                         res[11:4], res[3], res[2], res[1], res[0],
                         v[i].d, v[i].bo, v[i].ol, v[i].z, v[i].ov);
            end
        end
    endtask

    task automatic test_chain();
        vec_t v [6];
        logic [11:0] res;
        int c;
        int lat;
        // 0x0100-0x0001, 0x1234-0x1234, and a mid-word raw overflow that must not show.
        v[0] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        v[2] = '{8'h34, 8'h34, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        v[3] = '{8'h12, 8'h12, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        v[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
        v[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 3; t++) begin
            send(v[2*t], c);
            send(v[2*t+1], c);
            in_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                get_out(res, lat);
                total++;
                if (res !== {v[2*t+k].d, v[2*t+k].bo, v[2*t+k].ol, v[2*t+k].z, v[2*t+k].ov}) begin
                    bad++;
                    $display("FAIL chain[%0d]: got %h/%b/%b/%b/%b, required %h/%b/%b/%b/%b", 2*t+k,
                             res[11:4], res[3], res[2], res[1], res[0],
                             v[2*t+k].d, v[2*t+k].bo, v[2*t+k].ol, v[2*t+k].z, v[2*t+k].ov);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        vec_t v [4];
        // 32-bit 0x10050000 - 0x0F050001, least-significant word first.
        v[0] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        v[2] = '{8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        v[3] = '{8'h10, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b0;
        fork
            begin
                int c;
                for (int i = 0; i < 4; i++) send(v[i], c);
                in_valid = 1'b0;
            end
            begin
                logic [11:0] res;
                int lat;
                repeat (3) @(negedge clk);
                total++;
                if ({in_ready, out_valid, diff} !== {1'b0, 1'b1, 8'hFF}) begin
                    bad++;
                    $display("FAIL bp_stall: in_ready/out_valid/diff got %b/%b/%h, required 0/1/ff",
                             in_ready, out_valid, diff);
                end
                repeat (3) @(negedge clk);
                total++;
                if ({in_ready, out_valid, diff, bout} !== {1'b0, 1'b1, 8'hFF, 1'b1}) begin
                    bad++;
                    $display("FAIL bp_hold: in_ready/out_valid/diff/bout got %b/%b/%h/%b, required 0/1/ff/1",
                             in_ready, out_valid, diff, bout);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    get_out(res, lat);
                    total++;
                    if (res !== {v[i].d, v[i].bo, v[i].ol, v[i].z, v[i].ov}) begin
                        bad++;
                        $display("FAIL bp_order[%0d]: got %h/%b/%b/%b/%b, required %h/%b/%b/%b/%b", i,
                                 res[11:4], res[3], res[2], res[1], res[0],
                                 v[i].d, v[i].bo, v[i].ol, v[i].z, v[i].ov);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        vec_t v [4];
        logic [11:0] res;
        int c;
        int lat;
        v[0] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        // After reset: borrow chain must be 0 and the zero accumulator re-armed.
        v[2] = '{8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        v[3] = '{8'h03, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        send(v[0], c);
        send(v[1], c);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, diff, bout, out_last, zero, ovf, in_ready} !== 14'b00000000000001) begin
            bad++;
            $display("FAIL rst_mid_async: out_valid/diff/bout/last/zero/ovf/in_ready got %b, required 0..0/1",
                     {out_valid, diff, bout, out_last, zero, ovf, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_flush: out_valid got %b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        send(v[2], c);
        send(v[3], c);
        in_valid = 1'b0;
        for (int k = 2; k < 4; k++) begin
            get_out(res, lat);
            total++;
            if (res !== {v[k].d, v[k].bo, v[k].ol, v[k].z, v[k].ov}) begin
                bad++;
                $display("FAIL rst_mid_after[%0d]: got %h/%b/%b/%b/%b, required %h/%b/%b/%b/%b", k,
                         res[11:4], res[3], res[2], res[1], res[0],
                         v[k].d, v[k].bo, v[k].ol, v[k].z, v[k].ov);
            end
        end
    endtask

    task automatic test_restart();
        vec_t v [2];
        logic [11:0] res;
        int c;
        int lat;
        v[0] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
        v[1] = '{8'h05, 8'h01, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0};
        send(v[0], c);
        send(v[1], c);
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            get_out(res, lat);
            total++;
            if (res !== {v[k].d, v[k].bo, v[k].ol, v[k].z, v[k].ov}) begin
                bad++;
                $display("FAIL restart[%0d]: got %h/%b/%b/%b/%b, required %h/%b/%b/%b/%b", k,
                         res[11:4], res[3], res[2], res[1], res[0],
                         v[k].d, v[k].bo, v[k].ol, v[k].z, v[k].ov);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [6];
        int cycles_sum = 0;
        v[0] = '{8'h20, 8'h10, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0};
        v[1] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
        v[2] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        v[3] = '{8'h33, 8'h33, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        v[4] = '{8'h80, 8'h7F, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        v[5] = '{8'h01, 8'h02, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        fork
            begin
                int c;
                for (int i = 0; i < 6; i++) begin
                    send(v[i], c);
                    cycles_sum += c;
                end
                in_valid = 1'b0;
            end
            begin
                logic [11:0] res;
                int lat;
                for (int i = 0; i < 6; i++) begin
                    get_out(res, lat);
                    total++;
                    if (res !== {v[i].d, v[i].bo, v[i].ol, v[i].z, v[i].ov}) begin
                        bad++;
                        $display("FAIL b2b[%0d]: got %h/%b/%b/%b/%b, required %h/%b/%b/%b/%b", i,
                                 res[11:4], res[3], res[2], res[1], res[0],
                                 v[i].d, v[i].bo, v[i].ol, v[i].z, v[i].ov);
                    end
                end
            end
        join
        total++;
        if (cycles_sum !== 6) begin
            bad++;
            $display("FAIL b2b_throughput: 6 beats took %0d cycles, required 6", cycles_sum);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_borrow_ovf();
        test_chain();
        test_backpressure();
        test_reset_mid();
        test_restart();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
